// File: rtl/quick_spi_pkg.sv
// quick_spi_pkg: shared definitions for the QuickSPI family.
//   spi_state_t  - controller state encoding (IDLE, SETUP, SHIFT, HOLD)
//   MODE0..MODE3 - SPI mode as {cpol, cpha}
//   READ / WRITE - transfer direction constants shared with quick_spi
package quick_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

endpackage

// File: rtl/quick_spi_sclk_gen.sv
// quick_spi_sclk_gen: SCLK timing for the burst master.
//   clk, reset_n : system clock, synchronous active-low reset
//   enable       : counts while high, counter held at 0 while low
//   shift        : high while SCLK edges are being generated
//   clk_div      : half-period H = clk_div + 1 clk cycles
//   tick         : one-cycle pulse at the end of every half-period
//   leading      : when shift is high, the current tick is a leading edge
module quick_spi_sclk_gen #(
  parameter int CLK_DIV_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     shift,
  input  logic [CLK_DIV_WIDTH-1:0] clk_div,
  output logic                     tick,
  output logic                     leading
);

  logic [CLK_DIV_WIDTH-1:0] cnt_q;
  logic                     leading_q;

  assign tick    = enable && (cnt_q == clk_div);
  assign leading = leading_q;

  // Reloads to 0 on every tick, so clk_div = all-ones gives H = 2^CLK_DIV_WIDTH.
  always_ff @(posedge clk) begin
    if (!reset_n || !enable) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CLK_DIV_WIDTH'(1);
    end
  end

  // Outside SHIFT the next edge is always a leading one; a word has an even
  // number of edges, so parity carries straight across word boundaries.
  always_ff @(posedge clk) begin
    if (!reset_n || !shift) begin
      leading_q <= 1'b1;
    end else if (tick) begin
      leading_q <= ~leading_q;
    end
  end

endmodule

// File: rtl/quick_spi_burst_master.sv
// quick_spi_burst_master: full-duplex, MSB-first SPI master with bursts of
// num_words words under one slave select, all four SPI modes.
//   clk, reset_n        : system clock, synchronous active-low reset
//   start_transaction   : request, accepted on a clk edge where ready=1
//   ready               : idle; config inputs and tx_data word 0 are latched
//                         on the accepting edge
//   slave, cpol, cpha, clk_div, num_words : per-transaction configuration
//   tx_data / tx_ack    : tx_ack pulses the cycle after tx_data was captured
//   rx_data / rx_valid  : rx_valid pulses when rx_data holds a new word
//   end_of_transaction  : one-cycle pulse when the burst completes
//   mosi, miso, sclk, ss_n : SPI bus
// Handshake: a request is taken only when start_transaction && ready at a
// clk edge; tx_ack and rx_valid are single-cycle strobes with no back-pressure,
// so the host must present the next tx word before the final edge of the
// current word.
module quick_spi_burst_master
  import quick_spi_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int NUMBER_OF_SLAVES = 2,
  parameter int SLAVE_SEL_WIDTH  = 1,
  parameter int CLK_DIV_WIDTH    = 8,
  parameter int BURST_WIDTH      = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start_transaction,
  output logic                        ready,
  input  logic [SLAVE_SEL_WIDTH-1:0]  slave,
  input  logic                        cpol,
  input  logic                        cpha,
  input  logic [CLK_DIV_WIDTH-1:0]    clk_div,
  input  logic [BURST_WIDTH-1:0]      num_words,
  input  logic [DATA_WIDTH-1:0]       tx_data,
  output logic                        tx_ack,
  output logic [DATA_WIDTH-1:0]       rx_data,
  output logic                        rx_valid,
  output logic                        end_of_transaction,
  output logic                        mosi,
  input  logic                        miso,
  output logic                        sclk,
  output logic [NUMBER_OF_SLAVES-1:0] ss_n
);

  localparam int EDGE_W = $clog2(2 * DATA_WIDTH);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH - 1);

  spi_state_t state_q, state_d;

  logic                        cpha_q;
  logic [CLK_DIV_WIDTH-1:0]    div_q;
  logic [BURST_WIDTH-1:0]      words_rem_q;
  logic [EDGE_W-1:0]           edge_cnt_q;
  logic [DATA_WIDTH-1:0]       tx_sr_q, rx_sr_q, rx_data_q, rx_next;
  logic                        mosi_q, sclk_q, tx_ack_q, rx_valid_q, eot_q;
  logic [NUMBER_OF_SLAVES-1:0] ss_n_q, ss_sel;

  logic tick, leading;
  logic accept, edge_now, last_edge, more_words, sample_now, drive_now, next_word;

  quick_spi_sclk_gen #(.CLK_DIV_WIDTH(CLK_DIV_WIDTH)) u_sclk_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (state_q != ST_IDLE),
    .shift   (state_q == ST_SHIFT),
    .clk_div (div_q),
    .tick    (tick),
    .leading (leading)
  );

  assign ready      = (state_q == ST_IDLE);
  assign accept     = ready && start_transaction;
  assign edge_now   = (state_q == ST_SHIFT) && tick;
  assign last_edge  = edge_now && (edge_cnt_q == LAST_EDGE);
  assign more_words = (words_rem_q != '0);
  assign next_word  = last_edge && more_words;
  // cpha=0 samples on leading edges, cpha=1 on trailing; the other edge drives.
  assign sample_now = edge_now && (leading != cpha_q);
  assign drive_now  = edge_now && (leading == cpha_q);
  assign rx_next    = sample_now ? {rx_sr_q[DATA_WIDTH-2:0], miso} : rx_sr_q;

  // Out-of-range slave index matches no bit, leaving every select high.
  always_comb begin
    ss_sel = '1;
    for (int i = 0; i < NUMBER_OF_SLAVES; i++) begin
      if (slave == SLAVE_SEL_WIDTH'(i)) ss_sel[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_transaction) state_d = ST_SETUP;
      ST_SETUP: if (tick) state_d = ST_SHIFT;
      ST_SHIFT: if (last_edge && !more_words) state_d = ST_HOLD;
      ST_HOLD:  if (tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cpha_q      <= 1'b0;
      div_q       <= '0;
      words_rem_q <= '0;
      edge_cnt_q  <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      mosi_q      <= 1'b0;
      sclk_q      <= 1'b0;
      ss_n_q      <= '1;
      tx_ack_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      eot_q       <= 1'b0;
    end else begin
      tx_ack_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      eot_q      <= 1'b0;

      if (accept) begin
        cpha_q      <= cpha;
        div_q       <= clk_div;
        words_rem_q <= (num_words == '0) ? '0 : num_words - BURST_WIDTH'(1);
        edge_cnt_q  <= '0;
        rx_sr_q     <= '0;
        sclk_q      <= cpol;
        ss_n_q      <= ss_sel;
        tx_ack_q    <= 1'b1;
        // cpha=0 presents the MSB before the first edge; cpha=1 drives it on
        // the first leading edge instead.
        if (cpha) begin
          tx_sr_q <= tx_data;
          mosi_q  <= 1'b0;
        end else begin
          tx_sr_q <= {tx_data[DATA_WIDTH-2:0], 1'b0};
          mosi_q  <= tx_data[DATA_WIDTH-1];
        end
      end

      if (edge_now) begin
        sclk_q     <= ~sclk_q;
        edge_cnt_q <= last_edge ? '0 : edge_cnt_q + EDGE_W'(1);
        if (sample_now) rx_sr_q <= rx_next;
        if (last_edge) begin
          rx_data_q  <= rx_next;
          rx_valid_q <= 1'b1;
        end
        if (next_word) begin
          words_rem_q <= words_rem_q - BURST_WIDTH'(1);
          tx_ack_q    <= 1'b1;
          if (cpha_q) begin
            tx_sr_q <= tx_data;
          end else begin
            tx_sr_q <= {tx_data[DATA_WIDTH-2:0], 1'b0};
            mosi_q  <= tx_data[DATA_WIDTH-1];
          end
        end else if (drive_now && !last_edge) begin
          // The final trailing edge of the last word drives nothing.
          mosi_q  <= tx_sr_q[DATA_WIDTH-1];
          tx_sr_q <= {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
        end
      end

      // sclk already sits at cpol here and stays there while idle.
      if ((state_q == ST_HOLD) && tick) begin
        ss_n_q <= '1;
        mosi_q <= 1'b0;
        eot_q  <= 1'b1;
      end
    end
  end

  assign tx_ack             = tx_ack_q;
  assign rx_data            = rx_data_q;
  assign rx_valid           = rx_valid_q;
  assign end_of_transaction = eot_q;
  assign mosi               = mosi_q;
  assign sclk               = sclk_q;
  assign ss_n               = ss_n_q;

endmodule

// File: tb/tb_quick_spi_burst_master.sv
// tb_quick_spi_burst_master: directed vectors for quick_spi_burst_master with
// DATA_WIDTH=8, NUMBER_OF_SLAVES=2, SLAVE_SEL_WIDTH=2 (so slave=3 is out of range).
module tb_quick_spi_burst_master;
  import quick_spi_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic       clk;
  logic       reset_n;
  logic       start_transaction;
  logic       ready;
  logic [1:0] slave;
  logic       cpol, cpha;
  logic [7:0] clk_div, num_words, tx_data, rx_data;
  logic       tx_ack, rx_valid, end_of_transaction;
  logic       mosi, miso, sclk;
  logic [1:0] ss_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  quick_spi_burst_master #(
    .DATA_WIDTH(8), .NUMBER_OF_SLAVES(2), .SLAVE_SEL_WIDTH(2),
    .CLK_DIV_WIDTH(8), .BURST_WIDTH(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_transaction(start_transaction),
    .ready(ready), .slave(slave), .cpol(cpol), .cpha(cpha), .clk_div(clk_div),
    .num_words(num_words), .tx_data(tx_data), .tx_ack(tx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .end_of_transaction(end_of_transaction), .mosi(mosi), .miso(miso),
    .sclk(sclk), .ss_n(ss_n)
  );

  // ---------------- slave model ----------------
  // Counts SCLK edges since slv_base, shifts in mosi on sample edges and
  // presents slv_reply MSB-first (or loops mosi back when slv_lb is set).
  logic       slv_cpha  = 1'b0;
  logic       slv_lb    = 1'b1;
  logic [7:0] slv_reply = 8'h00;
  logic [7:0] slv_rx    = 8'h00;
  logic       sclk_prev = 1'b0;
  int         slv_edges = 0;
  int         slv_base  = 0;
  int         slv_idx;

  always @(negedge clk) begin
    sclk_prev <= sclk;
    if (sclk !== sclk_prev) begin
      slv_edges <= slv_edges + 1;
      if ((((slv_edges + 1 - slv_base) % 2) == 1) != slv_cpha)
        slv_rx <= {slv_rx[6:0], mosi};
    end
  end

  always_comb begin
    if (slv_cpha) slv_idx = (slv_edges <= slv_base) ? 0 : (slv_edges - slv_base - 1) / 2;
    else          slv_idx = (slv_edges - slv_base) / 2;
    slv_idx = slv_idx % 8;
  end

  assign miso = slv_lb ? mosi : slv_reply[7 - slv_idx];

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         ack_cnt = 0, rv_cnt = 0, eot_cnt = 0, ss_err = 0;
  logic [1:0] exp_ss;
  logic [23:0] feed_words;
  int         feed_n, feed_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: wait for the negedge, then act as host and monitor.
  task automatic step();
    @(negedge clk);
    if (tx_ack) begin
      ack_cnt++;
      if (feed_idx < feed_n) tx_data = feed_words[8*feed_idx +: 8];
      feed_idx++;
    end
    if (rx_valid) begin
      rv_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rx_extra: got word %0h, expected no rx_valid", rx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rx_data !== e) begin
          n_fail++;
          $display("FAIL rx_word: got %0h, expected %0h", rx_data, e);
        end
      end
    end
    if (end_of_transaction) eot_cnt++;
    if (!ready && ss_n !== exp_ss) ss_err++;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  mode;   // {cpol, cpha}
    logic [7:0]  div;
    logic [7:0]  nw;
    logic [1:0]  slave;
    logic [23:0] words;  // word i in bits [8*i +: 8]
    logic        lb;
    logic [7:0]  reply;
    logic [1:0]  ss;
    int          lat;
    int          poke;   // cycle at which a busy-time start is attempted, -1 none
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input int id, input vec_t v);
    int w, lat, a0, r0, e0;
    logic [7:0] last_word;
    w = (v.nw == 0) ? 1 : int'(v.nw);
    exp_ss = v.ss; feed_words = v.words; feed_n = w; feed_idx = 1; ss_err = 0;
    slv_cpha = v.mode[0]; slv_lb = v.lb; slv_reply = v.reply;
    for (int i = 0; i < w; i++) exp_q.push_back(v.lb ? v.words[8*i +: 8] : v.reply);
    last_word = v.words[8*(w-1) +: 8];
    a0 = ack_cnt; r0 = rv_cnt; e0 = eot_cnt;
    {cpol, cpha} = v.mode; clk_div = v.div; num_words = v.nw; slave = v.slave;
    tx_data = v.words[7:0]; start_transaction = 1'b1;
    chk($sformatf("v%0d ready_idle", id), ready, 1);
    step();
    start_transaction = 1'b0;
    chk($sformatf("v%0d setup_sclk", id), sclk, v.mode[1]);
    chk($sformatf("v%0d setup_ready", id), ready, 0);
    step();
    slv_base = slv_edges;
    lat = 1;
    while (!ready && lat < 3000) begin
      if (lat == v.poke) begin
        start_transaction = 1'b1; slave = 2'd1; clk_div = 8'd0;
        num_words = 8'd5; tx_data = 8'hFF;
      end else begin
        start_transaction = 1'b0;
      end
      step();
      lat++;
    end
    chk($sformatf("v%0d latency", id), lat, v.lat);
    chk($sformatf("v%0d idle_sclk", id), sclk, v.mode[1]);
    chk($sformatf("v%0d idle_mosi", id), mosi, 0);
    chk($sformatf("v%0d idle_ss", id), ss_n, 2'b11);
    step(); step();
    chk($sformatf("v%0d tx_ack_count", id), ack_cnt - a0, w);
    chk($sformatf("v%0d rx_valid_count", id), rv_cnt - r0, w);
    chk($sformatf("v%0d eot_count", id), eot_cnt - e0, 1);
    chk($sformatf("v%0d ss_held", id), ss_err, 0);
    chk($sformatf("v%0d sclk_edges", id), slv_edges - slv_base, 16 * w);
    chk($sformatf("v%0d mosi_word", id), slv_rx, last_word);
    chk($sformatf("v%0d rx_data_last", id), rx_data, v.lb ? last_word : v.reply);
    chk($sformatf("v%0d rx_queue_left", id), exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, r0, e0;
    vecs[0] = '{MODE0, 8'd0, 8'd1, 2'd0, 24'h0000A5, 1'b1, 8'h00, 2'b10, 18, -1};
    vecs[1] = '{MODE1, 8'd3, 8'd1, 2'd0, 24'h00003C, 1'b0, 8'hC3, 2'b10, 72, -1};
    vecs[2] = '{MODE2, 8'd3, 8'd1, 2'd1, 24'h00003C, 1'b0, 8'hC3, 2'b01, 72, -1};
    vecs[3] = '{MODE3, 8'd3, 8'd1, 2'd0, 24'h00003C, 1'b0, 8'hC3, 2'b10, 72, -1};
    vecs[4] = '{MODE0, 8'd0, 8'd3, 2'd0, 24'h332211, 1'b1, 8'h00, 2'b10, 50, -1};
    vecs[5] = '{MODE0, 8'd0, 8'd0, 2'd3, 24'h00005A, 1'b1, 8'h00, 2'b11, 18, -1};
    vecs[6] = '{MODE3, 8'd0, 8'd2, 2'd1, 24'h006996, 1'b0, 8'hC3, 2'b01, 34, -1};
    vecs[7] = '{MODE2, 8'd1, 8'd1, 2'd1, 24'h00000F, 1'b0, 8'hF0, 2'b01, 36, -1};
    vecs[8] = '{MODE0, 8'd1, 8'd1, 2'd0, 24'h000081, 1'b1, 8'h00, 2'b10, 36, 8};

    reset_n = 1'b0; start_transaction = 1'b0; slave = 2'd0; cpol = 1'b0; cpha = 1'b0;
    clk_div = 8'd0; num_words = 8'd0; tx_data = 8'd0;
    exp_ss = 2'b11; feed_words = '0; feed_n = 0; feed_idx = 0;

    // Reset state
    repeat (3) step();
    chk("rst ready", ready, 1);
    chk("rst ss_n", ss_n, 2'b11);
    chk("rst sclk", sclk, 0);
    chk("rst mosi", mosi, 0);
    chk("rst rx_data", rx_data, 0);
    chk("rst strobes", {tx_ack, rx_valid, end_of_transaction}, 3'b000);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset at the posedge of edge 5 (mode 2, H=1): abort with no strobes.
    exp_ss = 2'b10; feed_n = 1; feed_idx = 1; slv_lb = 1'b1; slv_cpha = 1'b0;
    r0 = rv_cnt; e0 = eot_cnt;
    {cpol, cpha} = MODE2; clk_div = 8'd0; num_words = 8'd1; slave = 2'd0;
    tx_data = 8'hA5; start_transaction = 1'b1;
    step();
    start_transaction = 1'b0;
    repeat (5) step();
    chk("abort busy", ready, 0);
    chk("abort ss_before", ss_n, 2'b10);
    reset_n = 1'b0;
    step();
    chk("abort sclk", sclk, 0);
    chk("abort ss_n", ss_n, 2'b11);
    chk("abort ready", ready, 1);
    chk("abort mosi", mosi, 0);
    chk("abort rx_data", rx_data, 0);
    chk("abort strobes", {tx_ack, rx_valid, end_of_transaction}, 3'b000);
    reset_n = 1'b1;
    repeat (20) step();
    chk("abort no_rx_valid", rv_cnt - r0, 0);
    chk("abort no_eot", eot_cnt - e0, 0);

    // Back-to-back: start held high through ready rising.
    exp_ss = 2'b01; feed_n = 1; feed_idx = 1; slv_lb = 1'b1; slv_cpha = 1'b0; ss_err = 0;
    exp_q.push_back(8'h3C); exp_q.push_back(8'h3C);
    r0 = rv_cnt; e0 = eot_cnt;
    {cpol, cpha} = MODE0; clk_div = 8'd0; num_words = 8'd1; slave = 2'd1;
    tx_data = 8'h3C; start_transaction = 1'b1;
    step();
    lat = 0;
    while (!ready && lat < 3000) begin step(); lat++; end
    chk("b2b lat1", lat, 18);
    chk("b2b gap_ss", ss_n, 2'b11);
    step();
    chk("b2b accept_ready", ready, 0);
    chk("b2b accept_ss", ss_n, 2'b01);
    start_transaction = 1'b0;
    lat = 0;
    while (!ready && lat < 3000) begin step(); lat++; end
    chk("b2b lat2", lat, 18);
    repeat (2) step();
    chk("b2b eot_count", eot_cnt - e0, 2);
    chk("b2b rx_valid_count", rv_cnt - r0, 2);
    chk("b2b ss_held", ss_err, 0);
    chk("b2b rx_queue_left", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/quick_spi_burst_master.md
Name: quick_spi_burst_master

Overview:
- Next-generation SPI master for the QuickSPI family.
- Supports all four SPI modes, with CPOL/CPHA selected per transaction and a programmable SCLK divider.
- Parametrised word width and slave count; full-duplex, MSB-first.
- Bursts of N words under one slave select, with per-word TX acknowledge and RX valid strobes toward the host-side controller.

Parameters:
- DATA_WIDTH, 16: bits per SPI word, legal 4..32.
- NUMBER_OF_SLAVES, 2: number of ss_n lines, legal 1..16.
- SLAVE_SEL_WIDTH, 1: width of slave index; must be at least clog2(NUMBER_OF_SLAVES), minimum 1.
- CLK_DIV_WIDTH, 8: width of clk_div input.
- BURST_WIDTH, 8: width of num_words input.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- start_transaction  in  1  request; accepted only when ready=1.
- ready  out  1  idle and able to accept a start.
- slave  in  SLAVE_SEL_WIDTH  binary index of target slave.
- cpol  in  1  SCLK idle level.
- cpha  in  1  0 = sample on leading edge; 1 = sample on trailing edge.
- clk_div  in  CLK_DIV_WIDTH  half-period H = clk_div+1 clk cycles.
- num_words  in  BURST_WIDTH  words in burst; 0 is treated as 1.
- tx_data  in  DATA_WIDTH  outgoing word.
- tx_ack  out  1  one-cycle pulse when tx_data is captured.
- rx_data  out  DATA_WIDTH  last received word; held until next rx_valid.
- rx_valid  out  1  one-cycle pulse; rx_data is new.
- end_of_transaction  out  1  one-cycle pulse when the burst completes.
- mosi  out  1  serial out; driven 0 when idle.
- miso  in  1  serial in.
- sclk  out  1  SPI clock.
- ss_n  out  NUMBER_OF_SLAVES  active-low selects.

Behaviour:
- Reset (reset_n=0 at posedge): ready=1, tx_ack=0, rx_valid=0, end_of_transaction=0, rx_data=0, mosi=0, sclk=0, ss_n all 1, state IDLE. Reset mid-transfer aborts immediately; no end_of_transaction is generated.
- Accept: at posedge A, with state IDLE and start_transaction=1, latch slave, cpol, cpha, clk_div and num_words. tx_data is captured as word 0 and tx_ack pulses in cycle A+1. Starts while ready=0 are ignored. Config input changes mid-burst are ignored.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- SETUP, from cycle A+1:
  - ready=0; ss_n[slave]=0, other ss_n bits stay 1.
  - sclk=cpol.
  - If cpha=0, mosi = word0[DATA_WIDTH-1].
  - Lasts H cycles.
- SHIFT:
  - sclk toggles every H cycles; 2*DATA_WIDTH edges per word.
  - Edges alternate leading/trailing. Leading edge = departure from cpol.
  - cpha=0: sample miso on leading edges; shift the next bit onto mosi on trailing edges (except the final trailing edge of the last word).
  - cpha=1: shift on leading edges (first leading edge drives the MSB); sample on trailing edges.
- Word boundary, at the final edge of each word:
  - rx_data is loaded with the assembled word and rx_valid pulses the next cycle.
  - If more words remain, tx_data is captured in the same cycle as that final edge and tx_ack pulses the next cycle. The host must present the next word before that edge.
  - Between words there is no gap: ss_n stays low and SCLK continues at the same rate.
  - With cpha=0, the next word's MSB is driven on the final trailing edge.
- HOLD:
  - Entered after the last edge of the last word; sclk=cpol.
  - Lasts H cycles; then ss_n all 1, mosi=0, end_of_transaction pulses, ready=1, state IDLE.
  - A new start is accepted in the same cycle ready rises (back-to-back).
- Total latency (A+1 to ready rising) = (2*DATA_WIDTH*W + 2)*H cycles, where W = max(num_words, 1).
- Out-of-range slave index (slave >= NUMBER_OF_SLAVES): the transfer runs normally, ss_n stays all 1, rx_data is still reported.
- The divider counter is CLK_DIV_WIDTH bits wide and reloads on every edge. clk_div at all-ones gives maximum H = 2^CLK_DIV_WIDTH.
- The word counter is BURST_WIDTH bits, so a maximum burst of 2^BURST_WIDTH-1 words.

Decomposition:
- Package quick_spi_pkg: state encoding (IDLE, SETUP, SHIFT, HOLD), SPI mode constants (MODE0..MODE3 as {cpol,cpha}), READ/WRITE constants shared with quick_spi.
- One sub-module: quick_spi_sclk_gen. Takes the latched clk_div and an enable; emits an edge tick and a leading/trailing flag.
- Shift registers and FSM stay in the top module.

Test Plan:
- Mode 0, DATA_WIDTH=8, clk_div=0, tx_data=0xA5, miso looped to mosi -> 16 sclk edges, rx_data=0xA5, ready high 18 cycles after A+1, end_of_transaction one pulse.
- Modes 1/2/3, clk_div=3, tx_data=0x3C, slave model returns 0xC3 -> correct idle SCLK level per mode, mosi stable at every sample edge, rx_data=0xC3, total 72 cycles.
- Burst num_words=3, words 0x11/0x22/0x33 supplied per tx_ack -> 3 tx_ack, 3 rx_valid, ss_n low continuously for 48 edges, single end_of_transaction.
- num_words=0 and slave=3 with NUMBER_OF_SLAVES=2 -> one word transferred, ss_n stays 2'b11, rx_valid pulses once.
- reset_n=0 at edge 5 of a word -> next cycle sclk=0, ss_n all 1, ready=1, no end_of_transaction/rx_valid; start during busy ignored.
- Back-to-back: start held high -> second transfer accepted in the cycle ready rises, ss_n high for exactly one cycle between transfers.
